inertial_delay_gate: RTL and testbench
======================================

Name: inertial_delay_gate

Overview:
- Clocked, multi-channel successor to the continuous-assign AND gate with inertial delay.
- Per channel, combines in1[i] and in2[i] with a runtime-selectable logic function.
- out[i] follows the result only after it has stayed stable for DELAY consecutive clock samples; shorter pulses and glitches are swallowed.
- Used as a synthesizable glitch filter and delay gate in stimulus and datapath examples.

Parameters:
- WIDTH, 4: number of independent channels.
- DELAY, 10: inertial delay in clock cycles; legal range 1..255.
- RESET_VAL, 0: value loaded into out on reset; WIDTH bits, replicated constant.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mode  input  2  function select: 00 AND, 01 OR, 10 XOR, 11 NAND
- in1  input  WIDTH  operand A, one bit per channel
- in2  input  WIDTH  operand B, one bit per channel
- out  output  WIDTH  filtered, delayed result; registered
- changed  output  WIDTH  one-cycle pulse per channel when out[i] toggles; registered
- busy  output  1  high while any channel has a pending (counting) change; registered

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
  - All state updates occur only on the rising edge of clock.
- Combinational target per channel: t[i] = f(mode, in1[i], in2[i]).
  - mode is sampled every edge, exactly like the operands.
- Per channel state:
  - out[i] register.
  - cnt[i] counter, width max(1, clog2(DELAY)).
- Each rising edge, per channel, first matching rule applies:
  1. reset=1: out<=RESET_VAL, cnt<=0, changed<=0, busy<=0.
  2. t==out: cnt<=0, changed[i]<=0 (pending change cancelled; inertial rejection).
  3. t!=out and cnt==DELAY-1: out<=t, cnt<=0, changed[i]<=1.
  4. t!=out otherwise: cnt<=cnt+1, changed[i]<=0.
- Latency:
  - A target value first sampled differing from out at edge k, and held through edge k+DELAY-1, appears on out after edge k+DELAY-1.
  - Pulses lasting fewer than DELAY sampled cycles never reach out.
  - DELAY=1: plain registered gate, one-cycle latency, no filtering.
- Counter never exceeds DELAY-1; no wrap-around possible.
- Change from one pending value to another:
  - Single-bit channels have only one "different" value, so the count continues while t stays !=out.
  - A bounce back to out's value resets the count (rule 2).
- Mode change mid-count: the target is recomputed under the new mode.
  - If it still differs from out, counting continues uninterrupted.
  - If it equals out, the count clears.
- busy is registered: busy <= OR over channels of (next cnt != 0).
  - It is high the cycle after counting starts.
  - It is low in the cycle out updates, unless another channel is still counting.
- changed is registered alongside out; it is high for exactly the one cycle in which the new out value is first visible.
- Reset mid-count: all counters discard pending changes and out returns to RESET_VAL on that edge.
  - Inputs held after reset release start a fresh DELAY count.
- Channels are fully independent; simultaneous updates on several channels are allowed, with multiple changed bits set in the same cycle.

Test Plan (WIDTH=4, DELAY=10, RESET_VAL=0 unless stated):
- Reset held 2 cycles -> out=4'h0, changed=4'h0, busy=0; with in1=in2=4'hF applied during reset, out stays 0 until reset deasserts.
- Stable change: mode=AND, in1=in2=4'hF from edge k -> busy=1 from after edge k; out=4'hF and changed=4'hF visible after edge k+9 for exactly one cycle; busy=0 the same cycle.
- Glitch rejection: from out=4'hF, drop in1[0] to 0 for 5 cycles then restore -> out stays 4'hF, changed stays 0, busy high for 5 cycles then low.
- Boundary: in1[1] low for exactly 10 cycles -> out[1] falls after the 10th edge, then rises 10 cycles after restore; in1[2] low for 9 cycles -> out[2] never changes.
- Mode switch: out=4'h0 with in1=4'hA, in2=4'h5, mode=AND; switch to XOR -> all channels count, out=4'hF after 10 edges. Switching back to AND at cycle 6 clears all counters, and out stays 4'h0.
- Reset mid-count and DELAY=1: assert reset at count 7 -> no update, out=RESET_VAL; rerun with DELAY=1, RESET_VAL=4'hF -> out tracks f(in1,in2) one cycle later, and a one-cycle pulse passes through.

Source files
------------

// File: rtl/inertial_delay_gate.sv
// rtl/inertial_delay_gate.sv - multi-channel clocked logic gate with inertial-delay glitch filter
// Each channel's output follows its gate result only after it has held for DELAY samples.
module inertial_delay_gate #(
   parameter int                WIDTH     = 4,
   parameter int                DELAY     = 10,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] changed,
   output logic             busy
);

   localparam int            CW   = (DELAY > 1) ? $clog2(DELAY) : 1;
   localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] out_nxt;
   logic [WIDTH-1:0] changed_nxt;
   logic             busy_nxt;
   logic [CW-1:0]    cnt     [WIDTH];
   logic [CW-1:0]    cnt_nxt [WIDTH];

   always_comb begin
      target = '0;
      case (mode)
         2'b00: target = in1 & in2;
         2'b01: target = in1 | in2;
         2'b10: target = in1 ^ in2;
         2'b11: target = ~(in1 & in2);
         default: target = '0;
      endcase
   end

   // A sample that agrees with out cancels any pending change; only an
   // unbroken run of DELAY disagreeing samples is allowed through.
   always_comb begin
      out_nxt     = out;
      changed_nxt = '0;
      busy_nxt    = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (target[i] != out[i]) begin
            if (cnt[i] == LAST) begin
               out_nxt[i]     = target[i];
               changed_nxt[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
         if (cnt_nxt[i] != '0) begin
            busy_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out     <= RESET_VAL;
         changed <= '0;
         busy    <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         out     <= out_nxt;
         changed <= changed_nxt;
         busy    <= busy_nxt;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_inertial_delay_gate.sv
// tb/tb_inertial_delay_gate.sv - self-checking bench for inertial_delay_gate
// Two instances (DELAY=10/RESET_VAL=0 and DELAY=1/RESET_VAL=F) share stimulus and are checked against a history-based model.
module tb_inertial_delay_gate;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode  = 2'b00;
   logic [3:0] in1   = 4'h0;
   logic [3:0] in2   = 4'h0;
   logic [3:0] out_a, changed_a, out_b, changed_b;
   logic       busy_a, busy_b;

   int n_vec  = 0;
   int n_fail = 0;

   inertial_delay_gate #(.WIDTH(4), .DELAY(10), .RESET_VAL(4'h0)) dut_a (
      .clock(clock), .reset(reset), .mode(mode), .in1(in1), .in2(in2),
      .out(out_a), .changed(changed_a), .busy(busy_a)
   );

   inertial_delay_gate #(.WIDTH(4), .DELAY(1), .RESET_VAL(4'hF)) dut_b (
      .clock(clock), .reset(reset), .mode(mode), .in1(in1), .in2(in2),
      .out(out_b), .changed(changed_b), .busy(busy_b)
   );

   always #5 clock = ~clock;

   // Model: per channel, the list of target samples seen since reset. out
   // flips when the newest DELAY samples all disagree with it.
   bit         hist [8][$];
   logic [3:0] m_out  [2];
   logic [3:0] m_chg  [2];
   logic       m_busy [2];
   int         dly    [2] = '{10, 1};
   logic [3:0] rv     [2] = '{4'h0, 4'hF};

   function automatic logic [3:0] gate_fn(logic [1:0] m, logic [3:0] a, logic [3:0] b);
      case (m)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic model_edge();
      logic [3:0] t;
      t = gate_fn(mode, in1, in2);
      for (int m = 0; m < 2; m++) begin
         if (reset) begin
            for (int ch = 0; ch < 4; ch++) hist[m*4+ch].delete();
            m_out[m]  = rv[m];
            m_chg[m]  = 4'h0;
            m_busy[m] = 1'b0;
         end else begin
            m_busy[m] = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
               int  k;
               int  n;
               int  run;
               bit  all_diff;
               k = m*4 + ch;
               hist[k].push_back(t[ch]);
               if (hist[k].size() > 300) void'(hist[k].pop_front());
               n = hist[k].size();
               all_diff = (n >= dly[m]);
               for (int j = 0; j < dly[m] && j < n; j++)
                  if (hist[k][n-1-j] == m_out[m][ch]) all_diff = 1'b0;
               m_chg[m][ch] = all_diff;
               if (all_diff) m_out[m][ch] = t[ch];
               run = 0;
               for (int j = n - 1; j >= 0; j--) begin
                  if (hist[k][j] == m_out[m][ch]) break;
                  run++;
               end
               if (run > 0) m_busy[m] = 1'b1;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      chk("a.out",     out_a,            m_out[0]);
      chk("a.changed", changed_a,        m_chg[0]);
      chk("a.busy",    {3'b0, busy_a},   {3'b0, m_busy[0]});
      chk("b.out",     out_b,            m_out[1]);
      chk("b.changed", changed_b,        m_chg[1]);
      chk("b.busy",    {3'b0, busy_b},   {3'b0, m_busy[1]});
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // reset with all-ones operands applied
      reset = 1'b1; mode = 2'b00; in1 = 4'hF; in2 = 4'hF;
      steps(2);
      chk("reset.out_a", out_a, 4'h0);
      reset = 1'b0;
      steps(9);
      chk("stable.pre_a", out_a, 4'h0);
      steps(1);
      chk("stable.out_a", out_a, 4'hF);
      chk("stable.chg_a", changed_a, 4'hF);
      steps(3);

      // 5-cycle glitch on channel 0
      in1[0] = 1'b0; steps(5);
      in1[0] = 1'b1; steps(12);
      chk("glitch.out_a", out_a, 4'hF);

      // exactly DELAY cycles low on channel 1
      in1[1] = 1'b0; steps(10);
      chk("bound10.out_a", out_a, 4'hD);
      in1[1] = 1'b1; steps(10);
      chk("bound10.back_a", out_a, 4'hF);
      steps(2);

      // DELAY-1 cycles low on channel 2
      in1[2] = 1'b0; steps(9);
      in1[2] = 1'b1; steps(12);
      chk("bound9.out_a", out_a, 4'hF);

      // mode switch AND -> XOR
      reset = 1'b1; in1 = 4'hA; in2 = 4'h5; mode = 2'b00; steps(1);
      reset = 1'b0; steps(2);
      mode = 2'b10; steps(10);
      chk("mode.xor_a", out_a, 4'hF);

      // XOR then back to AND at cycle 6
      reset = 1'b1; mode = 2'b00; steps(1);
      reset = 1'b0; mode = 2'b10; steps(6);
      mode = 2'b00; steps(10);
      chk("mode.back_a", out_a, 4'h0);

      // reset mid-count
      reset = 1'b1; steps(1);
      reset = 1'b0; mode = 2'b10; steps(7);
      reset = 1'b1; steps(1);
      chk("midreset.out_a", out_a, 4'h0);
      chk("midreset.out_b", out_b, 4'hF);
      reset = 1'b0; steps(12);

      // randomized run
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0)   in1 = 4'($urandom);
         if ($urandom_range(0, 7) == 0)   in2 = 4'($urandom);
         if ($urandom_range(0, 29) == 0)  mode = 2'($urandom);
         if ($urandom_range(0, 19) == 0)  in1 = in1 ^ 4'(1 << $urandom_range(0, 3));
         reset = ($urandom_range(0, 199) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
